// File: rtl/dual_issue_scheduler_if.sv
// Decoder-to-scheduler pair handshake, issue lanes, flush and load writeback.
// master drives decode/flush/writeback/issue-ready; slave is the scheduler.
interface dual_issue_scheduler_if #(
    parameter int unsigned RS = 5,
    parameter int unsigned RD = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0][4:0]        in_op_code;
    logic [1:0][3:0]        in_sub_op_code;
    logic [1:0][RS-1:0]     in_rs1;
    logic [1:0][RS-1:0]     in_rs2;
    logic [1:0][RD-1:0]     in_rd;
    logic [1:0][31:0]       in_imm;

    logic [1:0]             iss_valid;
    logic                   iss_ready;
    logic [1:0][4:0]        iss_op_code;
    logic [1:0][3:0]        iss_sub_op_code;
    logic [1:0][RS-1:0]     iss_rs1;
    logic [1:0][RS-1:0]     iss_rs2;
    logic [1:0][RD-1:0]     iss_rd;
    logic [1:0][31:0]       iss_imm;

    logic                   flush;
    logic                   wb_valid;
    logic [RD-1:0]          wb_rd;

    modport master (
        output in_valid, in_op_code, in_sub_op_code, in_rs1, in_rs2, in_rd, in_imm,
        output iss_ready, flush, wb_valid, wb_rd,
        input  in_ready, iss_valid, iss_op_code, iss_sub_op_code, iss_rs1, iss_rs2,
        input  iss_rd, iss_imm
    );

    modport slave (
        input  in_valid, in_op_code, in_sub_op_code, in_rs1, in_rs2, in_rd, in_imm,
        input  iss_ready, flush, wb_valid, wb_rd,
        output in_ready, iss_valid, iss_op_code, iss_sub_op_code, iss_rs1, iss_rs2,
        output iss_rd, iss_imm
    );
endinterface

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: issues a decoded pair together or splits it on hazards.
// Optional load-use scoreboard enabled by `define DUAL_ISSUE_SCOREBOARD_EN.
module dual_issue_scheduler #(
    parameter int unsigned RS = 5,
    parameter int unsigned RD = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    dual_issue_scheduler_if.slave bus
);

    typedef enum logic [1:0] {StEmpty, StPair, StSingle} state_e;

    typedef struct packed {
        logic [4:0]    op;
        logic [3:0]    sub;
        logic [RS-1:0] rs1;
        logic [RS-1:0] rs2;
        logic [RD-1:0] rd;
        logic [31:0]   imm;
    } entry_t;

    function automatic logic is_mem(input logic [4:0] op);
        return (op == 5'b00000) || (op == 5'b01000);
    endfunction

    function automatic logic is_ctrl(input logic [4:0] op);
        return (op == 5'b11011) || (op == 5'b11001) || (op == 5'b11000);
    endfunction

    state_e     state_q, state_d;
    entry_t     h0_q, h0_d, h1_q, h1_d;
    entry_t     in0, in1, lane0, lane1;
    logic [1:0] iss_valid;
    logic       fire, drain, in_ready, accept, split;
    logic       h0_busy, h1_busy, lock;

    assign in0 = '{op: bus.in_op_code[0], sub: bus.in_sub_op_code[0], rs1: bus.in_rs1[0],
                   rs2: bus.in_rs2[0], rd: bus.in_rd[0], imm: bus.in_imm[0]};
    assign in1 = '{op: bus.in_op_code[1], sub: bus.in_sub_op_code[1], rs1: bus.in_rs1[1],
                   rs2: bus.in_rs2[1], rd: bus.in_rd[1], imm: bus.in_imm[1]};

`ifdef DUAL_ISSUE_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d, set_vec, clr_vec;
    logic        lock_q, lock_d;

    assign h0_busy = (h0_q.rs1 != '0 && busy_q[h0_q.rs1]) || (h0_q.rs2 != '0 && busy_q[h0_q.rs2]);
    assign h1_busy = (h1_q.rs1 != '0 && busy_q[h1_q.rs1]) || (h1_q.rs2 != '0 && busy_q[h1_q.rs2]);
    assign lock    = lock_q;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (fire && !bus.flush) begin
            if (lane0.op == 5'b00000 && lane0.rd != '0) set_vec[lane0.rd] = 1'b1;
            if (iss_valid[1] && lane1.op == 5'b00000 && lane1.rd != '0) set_vec[lane1.rd] = 1'b1;
        end
        if (bus.wb_valid) clr_vec[bus.wb_rd] = 1'b1;
        // A load firing beats a writeback to the same register; r0 is never busy.
        busy_d = ((busy_q & ~clr_vec) | set_vec) & ~32'd1;
        // Once a split is offered it stays split until it fires, so lane 1 cannot
        // appear mid-stall when the H1 source clears.
        lock_d = (state_q == StPair) && (iss_valid == 2'b01) && !bus.iss_ready && !bus.flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            lock_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            lock_q <= lock_d;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = bus.wb_valid ^ (^bus.wb_rd);
    assign h0_busy   = 1'b0;
    assign h1_busy   = 1'b0;
    assign lock      = 1'b0;
`endif

    assign split = (h0_q.rd != '0 && (h1_q.rs1 == h0_q.rd || h1_q.rs2 == h0_q.rd)) ||
                   (is_mem(h0_q.op) && is_mem(h1_q.op)) || is_ctrl(h0_q.op) || h1_busy || lock;

    always_comb begin
        iss_valid = 2'b00;
        unique case (state_q)
            StPair:   if (!h0_busy) iss_valid = split ? 2'b01 : 2'b11;
            StSingle: if (!h0_busy) iss_valid = 2'b01;
            default:  ;
        endcase
    end

    assign fire     = iss_valid[0] && bus.iss_ready;
    assign drain    = fire && (iss_valid[1] || state_q == StSingle);
    assign in_ready = !bus.flush && (state_q == StEmpty || drain);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        h0_d    = h0_q;
        h1_d    = h1_q;
        if (bus.flush) begin
            state_d = StEmpty;
        end else if (accept) begin
            state_d = StPair;
            h0_d    = in0;
            h1_d    = in1;
        end else if (fire) begin
            if (state_q == StPair && !iss_valid[1]) begin
                state_d = StSingle;
                h0_d    = h1_q;
            end else begin
                state_d = StEmpty;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            h0_q    <= '0;
            h1_q    <= '0;
        end else begin
            state_q <= state_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
        end
    end

    assign lane0 = iss_valid[0] ? h0_q : '0;
    assign lane1 = iss_valid[1] ? h1_q : '0;

    assign bus.in_ready        = in_ready;
    assign bus.iss_valid       = iss_valid;
    assign bus.iss_op_code     = {lane1.op, lane0.op};
    assign bus.iss_sub_op_code = {lane1.sub, lane0.sub};
    assign bus.iss_rs1         = {lane1.rs1, lane0.rs1};
    assign bus.iss_rs2         = {lane1.rs2, lane0.rs2};
    assign bus.iss_rd          = {lane1.rd, lane0.rd};
    assign bus.iss_imm         = {lane1.imm, lane0.imm};

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: directed cases with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_dual_issue_scheduler;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  sub;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } ins_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dual_issue_scheduler_if #(.RS(5), .RD(5)) bus ();

    dual_issue_scheduler #(.RS(5), .RD(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: held instructions in issue order, plus busy registers.
    ins_t        held[$];
    logic [31:0] mbusy = '0;
    logic        mlock = 1'b0;

    function automatic logic is_mem(input logic [4:0] op);
        return op == 5'b00000 || op == 5'b01000;
    endfunction

    function automatic logic is_ctrl(input logic [4:0] op);
        return op == 5'b11011 || op == 5'b11001 || op == 5'b11000;
    endfunction

    function automatic logic src_busy(input logic [4:0] r);
`ifdef DUAL_ISSUE_SCOREBOARD_EN
        return r != 0 && mbusy[r];
`else
        return r != r;
`endif
    endfunction

    function automatic logic [1:0] exp_valid();
        ins_t a, b;
        if (held.size() == 0) return 2'b00;
        a = held[0];
        if (src_busy(a.rs1) || src_busy(a.rs2)) return 2'b00;
        if (held.size() == 1) return 2'b01;
        b = held[1];
        if (mlock) return 2'b01;
        if (a.rd != 0 && (b.rs1 == a.rd || b.rs2 == a.rd)) return 2'b01;
        if (is_mem(a.op) && is_mem(b.op)) return 2'b01;
        if (is_ctrl(a.op)) return 2'b01;
        if (src_busy(b.rs1) || src_busy(b.rs2)) return 2'b01;
        return 2'b11;
    endfunction

    function automatic ins_t act_lane(input int l);
        return '{op: bus.iss_op_code[l], sub: bus.iss_sub_op_code[l], rs1: bus.iss_rs1[l],
                 rs2: bus.iss_rs2[l], rd: bus.iss_rd[l], imm: bus.iss_imm[l]};
    endfunction

    function automatic ins_t in_slot(input int l);
        return '{op: bus.in_op_code[l], sub: bus.in_sub_op_code[l], rs1: bus.in_rs1[l],
                 rs2: bus.in_rs2[l], rd: bus.in_rd[l], imm: bus.in_imm[l]};
    endfunction

    logic [1:0]  ev;
    ins_t        e0, e1, s0, s1;
    logic        mfire, mdrain, minr, macc, mlock_n;
    int          nfire;
    logic [31:0] nbusy;

    // Compare every cycle, then advance the model using the inputs present at the edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            held.delete();
            mbusy = '0;
            mlock = 1'b0;
        end
        ev     = exp_valid();
        e0     = ev[0] ? held[0] : '0;
        e1     = ev[1] ? held[1] : '0;
        mfire  = ev[0] && bus.iss_ready;
        mdrain = mfire && (ev == 2'b11 || held.size() == 1);
        minr   = !bus.flush && (held.size() == 0 || mdrain);
        check("iss_valid", 64'(bus.iss_valid), 64'(ev));
        check("in_ready", 64'(bus.in_ready), 64'(minr));
        check("lane0", 64'(act_lane(0)), 64'(e0));
        check("lane1", 64'(act_lane(1)), 64'(e1));
        if (rst_n) begin
            nfire   = (ev == 2'b11) ? 2 : 1;
            nbusy   = mbusy;
            mlock_n = 1'b0;
`ifdef DUAL_ISSUE_SCOREBOARD_EN
            if (bus.wb_valid) nbusy[bus.wb_rd] = 1'b0;
            if (mfire && !bus.flush)
                for (int i = 0; i < nfire; i++)
                    if (held[i].op == 5'b00000 && held[i].rd != 0) nbusy[held[i].rd] = 1'b1;
            nbusy[0] = 1'b0;
            mlock_n  = held.size() == 2 && ev == 2'b01 && !bus.iss_ready && !bus.flush;
`endif
            macc = bus.in_valid && minr;
            s0   = in_slot(0);
            s1   = in_slot(1);
            if (bus.flush) begin
                held.delete();
            end else if (macc) begin
                held.delete();
                held.push_back(s0);
                held.push_back(s1);
            end else if (mfire) begin
                for (int i = 0; i < nfire; i++) void'(held.pop_front());
            end
            mbusy = nbusy;
            mlock = mlock_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input logic [4:0] op, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
        bus.in_op_code[s]     = op;
        bus.in_sub_op_code[s] = 4'(s + 1);
        bus.in_rs1[s]         = rs1;
        bus.in_rs2[s]         = rs2;
        bus.in_rd[s]          = rd;
        bus.in_imm[s]         = imm;
    endtask

    logic [4:0] ops [8] = '{5'b00000, 5'b01000, 5'b11000, 5'b11011,
                            5'b11001, 5'b01100, 5'b00100, 5'b00010};

    initial begin
        bus.in_valid = 1'b0;
        bus.iss_ready = 1'b1;
        bus.flush = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_rd = '0;
        set_slot(0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        set_slot(1, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        tick();
        tick();
        check("reset_valid", 64'(bus.iss_valid), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_imm0", 64'(bus.iss_imm[0]), 64'd0);
        rst_n = 1'b1;

        // Independent pair, then a second pair accepted while the first issues.
        set_slot(0, 5'b01100, 5'd1, 5'd2, 5'd3, 32'h11);
        set_slot(1, 5'b00100, 5'd4, 5'd0, 5'd5, 32'h22);
        bus.in_valid = 1'b1;
        tick();
        set_slot(0, 5'b01100, 5'd1, 5'd2, 5'd3, 32'h33);
        set_slot(1, 5'b00100, 5'd4, 5'd0, 5'd5, 32'h44);
        #1;
        check("ind_valid", 64'(bus.iss_valid), 64'h3);
        check("ind_rd0", 64'(bus.iss_rd[0]), 64'd3);
        check("ind_rd1", 64'(bus.iss_rd[1]), 64'd5);
        check("ind_imm1", 64'(bus.iss_imm[1]), 64'h22);
        check("ind_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("ind_next_imm0", 64'(bus.iss_imm[0]), 64'h33);
        tick();

        // RAW hazard: slot 1 reads slot 0's destination.
        set_slot(0, 5'b01100, 5'd1, 5'd2, 5'd7, 32'hA0);
        set_slot(1, 5'b01100, 5'd1, 5'd7, 5'd8, 32'hB0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("raw_v1", 64'(bus.iss_valid), 64'h1);
        check("raw_rd0", 64'(bus.iss_rd[0]), 64'd7);
        check("raw_rd1_zero", 64'(bus.iss_rd[1]), 64'd0);
        tick();
        check("raw_v2", 64'(bus.iss_valid), 64'h1);
        check("raw_slot1_imm", 64'(bus.iss_imm[0]), 64'hB0);
        check("raw_slot1_rd", 64'(bus.iss_rd[0]), 64'd8);
        tick();
        check("raw_empty", 64'(bus.iss_valid), 64'h0);

        // Two stores with back-pressure.
        set_slot(0, 5'b01000, 5'd1, 5'd2, 5'd0, 32'h5000);
        set_slot(1, 5'b01000, 5'd3, 5'd4, 5'd0, 32'h5100);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("st_hold_valid", 64'(bus.iss_valid), 64'h1);
            check("st_hold_imm", 64'(bus.iss_imm[0]), 64'h5000);
            tick();
        end
        bus.iss_ready = 1'b1;
        #1;
        check("st_release_imm", 64'(bus.iss_imm[0]), 64'h5000);
        tick();
        check("st_second_imm", 64'(bus.iss_imm[0]), 64'h5100);
        check("st_second_valid", 64'(bus.iss_valid), 64'h1);
        tick();
        check("st_empty", 64'(bus.iss_valid), 64'h0);

        // Branch in slot 0, flush while slot 1 waits alone.
        set_slot(0, 5'b11000, 5'd1, 5'd2, 5'd0, 32'hC0);
        set_slot(1, 5'b01100, 5'd3, 5'd4, 5'd6, 32'hC1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("br_valid", 64'(bus.iss_valid), 64'h1);
        check("br_op", 64'(bus.iss_op_code[0]), 64'h18);
        tick();
        bus.flush = 1'b1;
        #1;
        check("br_flush_in_ready", 64'(bus.in_ready), 64'd0);
        check("br_single_imm", 64'(bus.iss_imm[0]), 64'hC1);
        tick();
        bus.flush = 1'b0;
        #1;
        check("br_after_valid", 64'(bus.iss_valid), 64'h0);
        check("br_after_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        check("br_no_slot1", 64'(bus.iss_valid), 64'h0);

`ifdef DUAL_ISSUE_SCOREBOARD_EN
        // Load r9 then a consumer of r9 waits for writeback.
        set_slot(0, 5'b00000, 5'd1, 5'd2, 5'd9, 32'hD0);
        set_slot(1, 5'b00100, 5'd3, 5'd4, 5'd10, 32'hD1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("sb_load_valid", 64'(bus.iss_valid), 64'h3);
        tick();
        set_slot(0, 5'b01100, 5'd9, 5'd0, 5'd11, 32'hE0);
        set_slot(1, 5'b01100, 5'd1, 5'd2, 5'd12, 32'hE1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("sb_stall", 64'(bus.iss_valid), 64'h0);
            tick();
        end
        bus.wb_valid = 1'b1;
        bus.wb_rd = 5'd9;
        #1;
        check("sb_wb_cycle", 64'(bus.iss_valid), 64'h0);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        check("sb_release", 64'(bus.iss_valid), 64'h3);
        check("sb_release_imm", 64'(bus.iss_imm[0]), 64'hE0);
        tick();
`endif

        // Asynchronous reset in the middle of a split.
        set_slot(0, 5'b01100, 5'd1, 5'd2, 5'd7, 32'hF0);
        set_slot(1, 5'b01100, 5'd7, 5'd2, 5'd8, 32'hF1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(bus.iss_valid), 64'h0);
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_mid_imm", 64'(bus.iss_imm[0]), 64'h0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic with small register indices to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < 2; s++)
                set_slot(s, ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.iss_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.wb_valid  = ($urandom_range(0, 9) < 3);
            bus.wb_rd     = 5'($urandom_range(0, 7));
            tick();
        end
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.iss_ready = 1'b1;
        bus.wb_valid = 1'b0;
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_issue_scheduler.md
# dual_issue_scheduler

Issue scheduler between the two-slot instruction decoder and the execution lanes of the superscalar core. It accepts one decoded instruction pair per handshake and issues both together when legal. When a hazard exists, it splits the pair: slot 0 issues first and slot 1 is held and reissued alone. An optional load-use scoreboard stalls issue on registers with pending load writeback.

## Interface
Parameters:
- `RS`, 5, source register index width
- `RD`, 5, destination register index width

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  decoded pair present
- `in_ready`  out  1  scheduler accepts pair this cycle
- `in_op_code[1:0]`  in  5 each  decoded opcode per slot
- `in_sub_op_code[1:0]`  in  4 each  sub-opcode per slot
- `in_rs1[1:0]`, `in_rs2[1:0]`  in  RS each  sources per slot
- `in_rd[1:0]`  in  RD each  destination per slot
- `in_imm[1:0]`  in  32 each  immediate per slot
- `iss_valid[1:0]`  out  2  lane valid; `iss_valid[1]` implies `iss_valid[0]`
- `iss_ready`  in  1  execution lanes accept the issue bundle
- `iss_op_code[1:0]`, `iss_sub_op_code[1:0]`, `iss_rs1[1:0]`, `iss_rs2[1:0]`, `iss_rd[1:0]`, `iss_imm[1:0]`  out  widths as inputs  issued fields
- `flush`  in  1  discard all held instructions
- `wb_valid`  in  1  load writeback occurring
- `wb_rd`  in  RD  load writeback destination

## Operation
- The holding register has 2 entries, H0 and H1. There are 3 FSM states:
  - EMPTY: nothing held.
  - PAIR: H0 and H1 are both valid.
  - SINGLE: only H0 is valid; it holds the leftover slot 1.
- Accept: the scheduler captures the pair into H0/H1 and goes to PAIR. `in_ready` is 1 in EMPTY, or when the current bundle fully drains this cycle. The drain condition is `iss_ready` asserted and every held entry issuing.
- Opcode classes:
  - mem: 00000 (load) and 01000 (store).
  - ctrl: 11011, 11001 and 11000.
  - load: 00000. Opcode 00000 with rd=0 is treated as a load that writes nothing.
- Split conditions in PAIR (any one forces a split):
  - H0 rd≠0 and (H1 rs1==H0 rd or H1 rs2==H0 rd).
  - H0 and H1 are both mem.
  - H0 is ctrl.
  - Under SCOREBOARD_EN, an H1 source is busy.
- PAIR with no split: `iss_valid`=2'b11. On fire, go to EMPTY, or back to PAIR if a new pair is accepted the same cycle.
- PAIR with split: `iss_valid`=2'b01. On fire, move H1 to H0 and go to SINGLE.
- SINGLE: `iss_valid`=2'b01 with H0. On fire, go to EMPTY, or to PAIR on a same-cycle accept.
- Stall (SCOREBOARD_EN only): if an H0 source (rs≠0) is busy, `iss_valid`=2'b00 and the state holds.
- Fire: `iss_valid[0] && iss_ready`. No issued field may change while `iss_valid[0]=1` and `iss_ready=0`.
- Flush: state goes to EMPTY and held entries are dropped. `in_ready` is 0 during flush. Flush overrides fire and accept in the same cycle. The scoreboard is not modified.
- Lane fields with `iss_valid` low drive 0.

## Timing
- Reset values: state EMPTY, H0/H1 cleared, `iss_valid`=2'b00, `in_ready`=1, all `iss_*` fields 0, scoreboard all 0. Reset is asynchronous at any time, including mid-split; held instructions are lost.
- Latency: a pair accepted at edge N is presented on `iss_*` in cycle N+1 (one register stage).
- Split pair: slot 0 issues in cycle N+1 and slot 1 in cycle N+2 at the earliest.
- Throughput: one pair per cycle when no split and no stall.
- Issue outputs are combinational from state registers and the scoreboard only, never from `in_*`.

## Configuration
- Macro: `DUAL_ISSUE_SCOREBOARD_EN`.
- Defined: a 32-bit busy vector is maintained.
  - Bit rd is set when a load with rd≠0 fires on any lane.
  - Bit `wb_rd` is cleared when `wb_valid` is asserted.
  - If set and clear hit the same register in the same cycle, set wins.
  - Register 0 is never busy.
  - Busy-source stall and split rules apply.
- Undefined: no busy vector. `wb_valid`/`wb_rd` are ignored and the busy terms are 0.

## Test plan
- Independent pair (slot0 op 01100 rd=3; slot1 op 00100 rs1=4 rd=5), `iss_ready`=1 → cycle N+1 `iss_valid`=2'b11 with both lanes matching inputs; the next pair is accepted the same cycle.
- RAW pair (slot0 rd=7; slot1 rs2=7) → N+1 `iss_valid`=01 with slot0; N+2 `iss_valid`=01 with lane 0 carrying slot1; then EMPTY.
- Two stores (op 01000, both slots) with `iss_ready` low for 3 cycles → `iss_valid`=01 held stable, fields unchanged; split completes after `iss_ready` rises.
- Branch in slot0 (op 11000), flush asserted in the SINGLE cycle → `iss_valid`=00 the next cycle, `in_ready`=1, no slot1 issue.
- With `DUAL_ISSUE_SCOREBOARD_EN`: issue a load rd=9, then a pair with slot0 rs1=9 → `iss_valid`=00 until `wb_valid`=1 with `wb_rd`=9; issue occurs the cycle after. Also pulse `rst_n` low mid-split → outputs at reset values immediately.
